// File: rtl/sort_sequencer.sv
// Serial 4-element descending sorter: loads elements one per handshake, then runs the
// 5-comparator sorting network on one shared compare-exchange unit, one step per cycle.
module sort_sequencer #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [4*W-1:0] out_data,
  input  logic           out_ready,
  output logic           busy
);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DONE
  } state_t;

  state_t       state;
  logic [1:0]   count;
  logic [2:0]   step;
  logic [W-1:0] slot      [4];
  logic [W-1:0] next_slot [4];
  logic [1:0]   a_idx;
  logic [1:0]   b_idx;
  logic         swap;

  // Comparator schedule of the 4-input network: (0,1) (2,3) (0,2) (1,3) (1,2)
  always_comb begin
    a_idx = 2'd0;
    b_idx = 2'd1;
    case (step)
      3'd0: begin a_idx = 2'd0; b_idx = 2'd1; end
      3'd1: begin a_idx = 2'd2; b_idx = 2'd3; end
      3'd2: begin a_idx = 2'd0; b_idx = 2'd2; end
      3'd3: begin a_idx = 2'd1; b_idx = 2'd3; end
      3'd4: begin a_idx = 2'd1; b_idx = 2'd2; end
      default: begin a_idx = 2'd0; b_idx = 2'd1; end
    endcase
  end

  // Strict less-than, so equal elements never swap
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      next_slot[i] = slot[i];
    end
    swap = (slot[a_idx] < slot[b_idx]);
    if (swap) begin
      next_slot[a_idx] = slot[b_idx];
      next_slot[b_idx] = slot[a_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      count     <= 2'd0;
      step      <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        slot[i] <= '0;
      end
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            slot[count] <= in_data;
            count       <= count + 2'd1;
            if (count == 2'd3) begin
              state    <= SORT;
              step     <= 3'd0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < 4; i++) begin
            slot[i] <= next_slot[i];
          end
          if (step == 3'd4) begin
            // Result is latched from the post-exchange value so out_data is final on entry
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= {next_slot[0], next_slot[1], next_slot[2], next_slot[3]};
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= LOAD;
            count     <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed self-checking bench for sort_sequencer with hand-computed sorted results.
module tb_sort_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;

  int num_checks;
  int num_fails;

  sort_sequencer #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1ns past it for sampling and driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  // Feed four elements back-to-back, wait for the result and check latency and busy width
  task automatic runSort(input string tag, input logic [15:0] elems, input logic [15:0] expected,
                         input bit release_out);
    int cycles;
    int busy_cycles;
    logic [15:0] e;
    e = elems;
    applyStimulus(e[15:12]);
    applyStimulus(e[11:8]);
    applyStimulus(e[7:4]);
    applyStimulus(e[3:0]);
    cycles = 0;
    busy_cycles = 0;
    while (!out_valid && cycles < 20) begin
      if (busy) busy_cycles++;
      tick();
      cycles++;
    end
    checkOutput({tag, "_latency"}, 16'(cycles), 16'd5);
    checkOutput({tag, "_busy_cycles"}, 16'(busy_cycles), 16'd5);
    checkOutput({tag, "_data"}, out_data, expected);
    checkOutput({tag, "_in_ready_done"}, {15'd0, in_ready}, 16'd0);
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, "_in_ready_after"}, {15'd0, in_ready}, 16'd1);
      checkOutput({tag, "_out_valid_after"}, {15'd0, out_valid}, 16'd0);
      checkOutput({tag, "_out_data_after"}, out_data, 16'h0000);
    end
  endtask

  initial begin
    logic       gap_valid [7];
    logic [3:0] gap_data  [7];
    int         cycles;

    num_checks = 0;
    num_fails  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("reset_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("reset_out_data", out_data, 16'h0000);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);

    runSort("t1_3919", 16'h3919, 16'h9931, 1'b1);
    runSort("t2_f00f", 16'hF00F, 16'hFF00, 1'b1);
    runSort("t2_5555", 16'h5555, 16'h5555, 1'b1);
    runSort("t3_sorted", 16'h8642, 16'h8642, 1'b1);
    runSort("t3_reverse", 16'h2468, 16'h8642, 1'b1);

    // Gapped input: only the valid beats 7,1,C,3 are taken
    gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gap_data  = '{4'h7, 4'hF, 4'hE, 4'h1, 4'hD, 4'hC, 4'h3};
    for (int i = 0; i < 7; i++) begin
      in_valid = gap_valid[i];
      in_data  = gap_data[i];
      tick();
    end
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("t4_latency", 16'(cycles), 16'd5);
    checkOutput("t4_data", out_data, 16'hC731);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t4_in_ready_after", {15'd0, in_ready}, 16'd1);

    // Backpressure in DONE with in_valid pulses that must be ignored
    runSort("t5_1234", 16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 4'hF;
      tick();
      checkOutput($sformatf("t5_hold_valid_%0d", i), {15'd0, out_valid}, 16'd1);
      checkOutput($sformatf("t5_hold_data_%0d", i), out_data, 16'h4321);
      checkOutput($sformatf("t5_hold_in_ready_%0d", i), {15'd0, in_ready}, 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t5_release_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("t5_release_out_valid", {15'd0, out_valid}, 16'd0);
    runSort("t5_after", 16'h0F1E, 16'hFE10, 1'b1);

    // Reset sampled on the edge that would execute step2
    applyStimulus(4'h8);
    applyStimulus(4'h6);
    applyStimulus(4'h4);
    applyStimulus(4'h2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("t6_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("t6_out_data", out_data, 16'h0000);
    checkOutput("t6_busy", {15'd0, busy}, 16'd0);
    runSort("t6_abcd", 16'hABCD, 16'hDCBA, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
